regfile_mp: RTL and testbench

- Parametrised multi-port register file holding two banks: general (GPR) and floating (FPR), selected per access by a gf flag.
- Replaces the fixed writer/registers/two-reader arrangement with NREAD read ports, NWRITE write ports, same-cycle write-to-read bypass, and a per-register busy scoreboard for long-latency producers.
- Sits between decode (reads, reservations) and writeback (writes).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_bank.sv | 73 +++++++
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the dual-bank (GPR/FPR) multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned IDX_W      = $clog2(NREGS_DEF);

  typedef enum logic {
    GF_GPR = 1'b0,
    GF_FPR = 1'b1
  } gf_t;

  typedef struct packed {
    gf_t              gf;
    logic [IDX_W-1:0] num;
  } reg_addr_t;

endpackage

// File: rtl/regfile_bank.sv
// One bank of NREGS registers with busy bits; highest write port wins on collisions.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned NWRITE  = 2,
  parameter int unsigned NREAD   = 3,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NWRITE-1:0]                wr_en,
  input  logic [NWRITE-1:0][IDX_W-1:0]     wr_num,
  input  logic [NWRITE-1:0][DATA_W-1:0]    wr_data,
  input  logic                             rsv_en,
  input  logic [IDX_W-1:0]                 rsv_num,
  input  logic [NREAD-1:0][IDX_W-1:0]      rd_num,
  output logic [NREAD-1:0][DATA_W-1:0]     rd_data,
  output logic [NREAD-1:0]                 rd_busy
);

  logic [NREGS-1:0][DATA_W-1:0] r_data;
  logic [NREGS-1:0]             r_busy;
  logic [NREGS-1:0]             w_we;
  logic [NREGS-1:0]             w_rsv;
  logic [NREGS-1:0][DATA_W-1:0] w_wd;

  // Ascending port scan: a later (higher) port overrides earlier matches.
  always_comb begin
    w_we  = '0;
    w_wd  = '0;
    w_rsv = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (!(ZERO_R0 && r == 0)) begin
        for (int unsigned i = 0; i < NWRITE; i++) begin
          if (wr_en[i] && 32'(wr_num[i]) == r) begin
            w_we[r] = 1'b1;
            w_wd[r] = wr_data[i];
          end
        end
        w_rsv[r] = rsv_en && (32'(rsv_num) == r);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
      r_busy <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (w_we[r]) r_data[r] <= w_wd[r];
      end
      r_busy <= w_rsv | (r_busy & ~w_we);
    end
  end

  // Out-of-range indices match no register and fall through to zero.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (32'(rd_num[p]) == r) begin
          rd_data[p] = r_data[r];
          rd_busy[p] = r_busy[r];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR/FPR register file: bank steering, write-to-read bypass, busy masking.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned NREAD     = 3,
  parameter int unsigned NWRITE    = 2,
  parameter int unsigned NREGS     = NREGS_DEF,
  parameter bit          GPR0_ZERO = 1'b1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NREAD-1:0]              rd_gf,
  input  logic [NREAD-1:0][IDX_W-1:0]   rd_num,
  output logic [NREAD-1:0][DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]              rd_busy,
  input  logic [NWRITE-1:0]             wr_en,
  input  logic [NWRITE-1:0]             wr_gf,
  input  logic [NWRITE-1:0][IDX_W-1:0]  wr_num,
  input  logic [NWRITE-1:0][DATA_W-1:0] wr_data,
  input  logic                          rsv_en,
  input  logic                          rsv_gf,
  input  logic [IDX_W-1:0]              rsv_num
);

  logic [NWRITE-1:0]             w_g_wen;
  logic [NWRITE-1:0]             w_f_wen;
  logic                          w_g_rsv;
  logic                          w_f_rsv;
  logic [NREAD-1:0][DATA_W-1:0]  w_g_rdata;
  logic [NREAD-1:0][DATA_W-1:0]  w_f_rdata;
  logic [NREAD-1:0]              w_g_rbusy;
  logic [NREAD-1:0]              w_f_rbusy;
  reg_addr_t                     w_rd_addr [NREAD];
  reg_addr_t                     w_wr_addr [NWRITE];
  logic [NREAD-1:0]              w_rd_ok;
  logic [NREAD-1:0]              w_hit;
  logic [NREAD-1:0][DATA_W-1:0]  w_byp;

  assign w_g_wen = wr_en & ~wr_gf;
  assign w_f_wen = wr_en & wr_gf;
  assign w_g_rsv = rsv_en & (gf_t'(rsv_gf) == GF_GPR);
  assign w_f_rsv = rsv_en & (gf_t'(rsv_gf) == GF_FPR);

  regfile_bank #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .NWRITE (NWRITE),
    .NREAD  (NREAD),
    .ZERO_R0(GPR0_ZERO)
  ) u_gpr (
    .clk    (clk),
    .rstn   (rstn),
    .wr_en  (w_g_wen),
    .wr_num (wr_num),
    .wr_data(wr_data),
    .rsv_en (w_g_rsv),
    .rsv_num(rsv_num),
    .rd_num (rd_num),
    .rd_data(w_g_rdata),
    .rd_busy(w_g_rbusy)
  );

  regfile_bank #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .NWRITE (NWRITE),
    .NREAD  (NREAD),
    .ZERO_R0(1'b0)
  ) u_fpr (
    .clk    (clk),
    .rstn   (rstn),
    .wr_en  (w_f_wen),
    .wr_num (wr_num),
    .wr_data(wr_data),
    .rsv_en (w_f_rsv),
    .rsv_num(rsv_num),
    .rd_num (rd_num),
    .rd_data(w_f_rdata),
    .rd_busy(w_f_rbusy)
  );

  // Bypass only from writes that would actually land; dropped writes must not leak through.
  always_comb begin
    w_rd_ok = '0;
    w_hit   = '0;
    w_byp   = '0;
    for (int unsigned i = 0; i < NWRITE; i++) begin
      w_wr_addr[i] = '{gf: gf_t'(wr_gf[i]), num: wr_num[i]};
    end
    for (int unsigned p = 0; p < NREAD; p++) begin
      w_rd_addr[p] = '{gf: gf_t'(rd_gf[p]), num: rd_num[p]};
      w_rd_ok[p]   = (32'(rd_num[p]) < NREGS) &&
                     !(GPR0_ZERO && w_rd_addr[p].gf == GF_GPR && rd_num[p] == '0);
      for (int unsigned i = 0; i < NWRITE; i++) begin
        if (wr_en[i] && w_rd_ok[p] && w_wr_addr[i] == w_rd_addr[p]) begin
          w_hit[p] = 1'b1;
          w_byp[p] = wr_data[i];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      if (w_hit[p]) begin
        rd_data[p] = w_byp[p];
      end else if (gf_t'(rd_gf[p]) == GF_FPR) begin
        rd_data[p] = w_f_rdata[p];
        rd_busy[p] = w_f_rbusy[p];
      end else begin
        rd_data[p] = w_g_rdata[p];
        rd_busy[p] = w_g_rbusy[p];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, async reset sequence, random vs array model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NR   = 3;
  localparam int NW   = 2;
  localparam int DW   = 32;
  localparam int IW   = IDX_W;
  localparam int NREG = 32;
  localparam logic [5:0] F = 6'h20;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [NR-1:0]          rd_gf;
  logic [NR-1:0][IW-1:0]  rd_num;
  logic [NR-1:0][DW-1:0]  rd_data;
  logic [NR-1:0]          rd_busy;
  logic [NW-1:0]          wr_en;
  logic [NW-1:0]          wr_gf;
  logic [NW-1:0][IW-1:0]  wr_num;
  logic [NW-1:0][DW-1:0]  wr_data;
  logic                   rsv_en;
  logic                   rsv_gf;
  logic [IW-1:0]          rsv_num;

  regfile_mp #(
    .DATA_W(DW), .NREAD(NR), .NWRITE(NW), .NREGS(NREG), .GPR0_ZERO(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .rd_gf(rd_gf), .rd_num(rd_num), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_gf(wr_gf), .wr_num(wr_num), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_gf(rsv_gf), .rsv_num(rsv_num)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_data [2][NREG];
  bit            m_busy [2][NREG];

  typedef struct {
    logic [NW-1:0]         we;
    logic [NW-1:0][5:0]    wa;
    logic [NW-1:0][DW-1:0] wd;
    logic                  re;
    logic [5:0]            ra;
    logic [NR-1:0][5:0]    rda;
    logic [NR-1:0][DW-1:0] ed;
    logic [NR-1:0]         eb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic w0e, input logic [5:0] w0a, input logic [DW-1:0] w0d,
                              input logic w1e, input logic [5:0] w1a, input logic [DW-1:0] w1d,
                              input logic re, input logic [5:0] ra,
                              input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2, input logic [2:0] eb);
    vec_t v;
    v.we = {w1e, w0e};  v.wa[0] = w0a; v.wa[1] = w1a; v.wd[0] = w0d; v.wd[1] = w1d;
    v.re = re;          v.ra = ra;
    v.rda[0] = a0; v.rda[1] = a1; v.rda[2] = a2;
    v.ed[0] = e0;  v.ed[1] = e1;  v.ed[2] = e2;
    v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int g = 0; g < 2; g++)
      for (int r = 0; r < NREG; r++) begin
        m_data[g][r] = '0;
        m_busy[g][r] = 1'b0;
      end
  endtask

  // Expected read from the architectural state plus whatever is being written this cycle.
  task automatic model_read(input int gf, input int num, output logic [DW-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (gf == 0 && num == 0) return;
    d = m_data[gf][num];
    b = m_busy[gf][num];
    for (int i = 0; i < NW; i++)
      if (wr_en[i] && int'(wr_gf[i]) == gf && int'(wr_num[i]) == num) begin
        d = wr_data[i];
        b = 1'b0;
      end
  endtask

  task automatic model_commit();
    for (int i = 0; i < NW; i++)
      if (wr_en[i] && !(wr_gf[i] == 1'b0 && wr_num[i] == '0)) begin
        m_data[int'(wr_gf[i])][int'(wr_num[i])] = wr_data[i];
        m_busy[int'(wr_gf[i])][int'(wr_num[i])] = 1'b0;
      end
    if (rsv_en && !(rsv_gf == 1'b0 && rsv_num == '0))
      m_busy[int'(rsv_gf)][int'(rsv_num)] = 1'b1;
  endtask

  task automatic drive_idle();
    wr_en = '0; wr_gf = '0; wr_num = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_gf = 1'b0; rsv_num = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    for (int i = 0; i < NW; i++) begin
      wr_en[i]   = v.we[i];
      wr_gf[i]   = v.wa[i][5];
      wr_num[i]  = v.wa[i][IW-1:0];
      wr_data[i] = v.wd[i];
    end
    rsv_en = v.re; rsv_gf = v.ra[5]; rsv_num = v.ra[IW-1:0];
    for (int p = 0; p < NR; p++) begin
      rd_gf[p]  = v.rda[p][5];
      rd_num[p] = v.rda[p][IW-1:0];
    end
  endtask

  initial begin
    logic [DW-1:0] ed;
    logic          eb;
    vec_t          v;

    drive_idle();
    rd_gf = '0; rd_num = '0;
    rd_gf[1] = 1'b1; rd_num[0] = 5; rd_num[1] = 5; rd_num[2] = 31;
    model_clear();
    #2;
    for (int p = 0; p < NR; p++) begin
      check($sformatf("reset.rd_data[%0d]", p), rd_data[p], '0);
      check($sformatf("reset.rd_busy[%0d]", p), 32'(rd_busy[p]), '0);
    end
    @(negedge clk);
    rstn = 1'b1;

    vq.push_back(mk(0,0,0,           0,0,0,            0,0,   5,F|5,31,     0,0,0, 3'b000));
    vq.push_back(mk(1,7,32'h12345678,0,0,0,            0,0,   7,F|7,5,      32'h12345678,0,0, 3'b000));
    vq.push_back(mk(0,0,0,           0,0,0,            0,0,   7,F|7,7,      32'h12345678,0,32'h12345678, 3'b000));
    vq.push_back(mk(1,9,32'h1111,    1,9,32'h2222,     0,0,   9,9,9,        32'h2222,32'h2222,32'h2222, 3'b000));
    vq.push_back(mk(0,0,0,           0,0,0,            0,0,   9,F|9,7,      32'h2222,0,32'h12345678, 3'b000));
    vq.push_back(mk(1,0,32'hFFFFFFFF,0,0,0,            1,0,   0,F|0,0,      0,0,0, 3'b000));
    vq.push_back(mk(0,0,0,           1,F|0,32'hFFFFFFFF,0,0,  0,F|0,F|0,    0,32'hFFFFFFFF,32'hFFFFFFFF, 3'b000));
    vq.push_back(mk(0,0,0,           0,0,0,            1,F|4, F|0,F|4,0,    32'hFFFFFFFF,0,0, 3'b000));
    vq.push_back(mk(0,0,0,           0,0,0,            0,0,   F|4,F|4,4,    0,0,0, 3'b011));
    vq.push_back(mk(0,0,0,           1,F|4,32'hABCD,   0,0,   F|4,4,F|4,    32'hABCD,0,32'hABCD, 3'b000));
    vq.push_back(mk(0,0,0,           0,0,0,            0,0,   F|4,F|4,F|0,  32'hABCD,32'hABCD,32'hFFFFFFFF, 3'b000));
    vq.push_back(mk(1,12,32'h55,     0,0,0,            1,12,  12,12,F|12,   32'h55,32'h55,0, 3'b000));
    vq.push_back(mk(0,0,0,           0,0,0,            0,0,   12,7,9,       32'h55,32'h12345678,32'h2222, 3'b001));
    vq.push_back(mk(0,0,0,           0,0,0,            1,12,  7,9,F|4,      32'h12345678,32'h2222,32'hABCD, 3'b000));
    vq.push_back(mk(0,0,0,           0,0,0,            0,0,   12,12,F|0,    32'h55,32'h55,32'hFFFFFFFF, 3'b011));

    for (int k = 0; k < vq.size(); k++) begin
      v = vq[k];
      drive_vec(v);
      #2;
      for (int p = 0; p < NR; p++) begin
        check($sformatf("vec%0d.rd_data[%0d]", k, p), rd_data[p], v.ed[p]);
        check($sformatf("vec%0d.rd_busy[%0d]", k, p), 32'(rd_busy[p]), 32'(v.eb[p]));
      end
      @(posedge clk);
      model_commit();
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a low clock phase.
    drive_idle();
    wr_en[0] = 1'b1; wr_num[0] = 3; wr_data[0] = 32'hDEADBEEF;
    rd_gf = '0; rd_num[0] = 3; rd_num[1] = 12; rd_num[2] = 7;
    @(posedge clk);
    model_commit();
    @(negedge clk);
    drive_idle();
    #2;
    check("midrst.pre.gpr3", rd_data[0], 32'hDEADBEEF);
    check("midrst.pre.busy12", 32'(rd_busy[1]), 32'd1);
    rstn = 1'b0;
    #1;
    model_clear();
    check("midrst.gpr3", rd_data[0], '0);
    check("midrst.busy12", 32'(rd_busy[1]), '0);
    check("midrst.gpr12", rd_data[1], '0);
    check("midrst.gpr7", rd_data[2], '0);
    @(negedge clk);
    rstn = 1'b1;

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int i = 0; i < NW; i++) begin
        wr_en[i]   = ($urandom_range(0, 2) != 0);
        wr_gf[i]   = 1'($urandom_range(0, 1));
        wr_num[i]  = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(0, NREG - 1))
                                                 : IW'($urandom_range(0, 7));
        wr_data[i] = $urandom;
      end
      rsv_en  = ($urandom_range(0, 2) == 0);
      rsv_gf  = 1'($urandom_range(0, 1));
      rsv_num = IW'($urandom_range(0, 7));
      for (int p = 0; p < NR; p++) begin
        rd_gf[p]  = 1'($urandom_range(0, 1));
        rd_num[p] = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(0, NREG - 1))
                                                : IW'($urandom_range(0, 7));
      end
      #2;
      for (int p = 0; p < NR; p++) begin
        model_read(int'(rd_gf[p]), int'(rd_num[p]), ed, eb);
        check($sformatf("rnd%0d.rd_data[%0d]", n, p), rd_data[p], ed);
        check($sformatf("rnd%0d.rd_busy[%0d]", n, p), 32'(rd_busy[p]), 32'(eb));
      end
      @(posedge clk);
      model_commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
